// File: rtl/instr_fetch_latch.sv
// instr_fetch_latch: captures the OPR/OPA nibbles of each 8-cycle instruction
// cycle from the ROM nibble bus, fetches the second byte of two-word opcodes
// (JCN, JUN, JMS, ISZ, FIM) in the following instruction cycle, and then
// presents the complete instruction with a one-clock instrValid strobe.
// Optional feature macro: IFL_ICOUNT_EN adds a 16-bit wrapping instrCount
// output that counts delivered instructions.
module instr_fetch_latch #(
  parameter int M1_CYCLE = 3,
  parameter int M2_CYCLE = 4,
  parameter int X1_CYCLE = 5
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [2:0]  cycle,
  input  logic [3:0]  romNibble,
  output logic [3:0]  oprOut,
  output logic [3:0]  opaOut,
  output logic [7:0]  word2Out,
  output logic        twoWord,
  output logic        inWord2,
`ifdef IFL_ICOUNT_EN
  output logic [15:0] instrCount,
`endif
  output logic        instrValid
);

  localparam logic [2:0] M1_IDX = 3'(M1_CYCLE);
  localparam logic [2:0] M2_IDX = 3'(M2_CYCLE);
  localparam logic [2:0] X1_IDX = 3'(X1_CYCLE);

  typedef enum logic {FETCH1, FETCH2} state_t;

  state_t      stateReg, stateNext;
  logic [3:0]  oprReg, oprNext;
  logic [3:0]  opaReg, opaNext;
  logic [7:0]  word2Reg, word2Next;
  logic        twoWordReg, twoWordNext;
  logic        inWord2Reg, inWord2Next;
  logic        validReg, validNext;

  // Two-word opcodes: JCN, JUN, JMS, ISZ, and FIM (OPR 2 with even OPA).
  function automatic logic isTwoWord(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
           ((opr == 4'h2) && !opa[0]);
  endfunction

  // State and latched instruction fields; reset discards any partial fetch.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg   <= FETCH1;
      oprReg     <= '0;
      opaReg     <= '0;
      word2Reg   <= '0;
      twoWordReg <= 1'b0;
      inWord2Reg <= 1'b0;
      validReg   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      oprReg     <= oprNext;
      opaReg     <= opaNext;
      word2Reg   <= word2Next;
      twoWordReg <= twoWordNext;
      inWord2Reg <= inWord2Next;
      validReg   <= validNext;
    end
  end

  // Next-state and field updates keyed on the sampled cycle phase; all other
  // phases (and phases that never arrive) simply hold the current values.
  always_comb begin
    stateNext   = stateReg;
    oprNext     = oprReg;
    opaNext     = opaReg;
    word2Next   = word2Reg;
    twoWordNext = twoWordReg;
    inWord2Next = inWord2Reg;
    validNext   = 1'b0;
    case (stateReg)
      FETCH1: begin
        if (cycle == M1_IDX) begin
          oprNext     = romNibble;
          word2Next   = '0;
          twoWordNext = 1'b0;
        end else if (cycle == M2_IDX) begin
          opaNext = romNibble;
        end else if (cycle == X1_IDX) begin
          if (isTwoWord(oprReg, opaReg)) begin
            twoWordNext = 1'b1;
            inWord2Next = 1'b1;
            stateNext   = FETCH2;
          end else begin
            validNext = 1'b1;
          end
        end
      end
      FETCH2: begin
        if (cycle == M1_IDX) begin
          word2Next[7:4] = romNibble;
        end else if (cycle == M2_IDX) begin
          word2Next[3:0] = romNibble;
        end else if (cycle == X1_IDX) begin
          validNext   = 1'b1;
          inWord2Next = 1'b0;
          stateNext   = FETCH1;
        end
      end
      default: stateNext = FETCH1;
    endcase
  end

`ifdef IFL_ICOUNT_EN
  logic [15:0] countReg;

  // Count delivered instructions; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      countReg <= '0;
    end else if (validReg) begin
      countReg <= countReg + 16'd1;
    end
  end

  assign instrCount = countReg;
`endif

  assign oprOut     = oprReg;
  assign opaOut     = opaReg;
  assign word2Out   = word2Reg;
  assign twoWord    = twoWordReg;
  assign inWord2    = inWord2Reg;
  assign instrValid = validReg;

endmodule

// File: tb/tb_instr_fetch_latch.sv
// Testbench for instr_fetch_latch: directed test-plan steps followed by random
// instruction bytes, checked against an instruction-level reference model.
module tb_instr_fetch_latch;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  cycle;
  logic [3:0]  romNibble;
  logic [3:0]  oprOut, opaOut;
  logic [7:0]  word2Out;
  logic        twoWord, inWord2, instrValid;
`ifdef IFL_ICOUNT_EN
  logic [15:0] instrCount;
`endif

  int passCount  = 0;
  int totalCount = 0;

  // Reference model state (instruction level)
  logic [3:0]  mOpr, mOpa;
  logic [7:0]  mWord2;
  logic        mTwo, mIn2;
  logic [15:0] mCount;

  instr_fetch_latch dut (
    .clk        (clk),
    .rstN       (rstN),
    .cycle      (cycle),
    .romNibble  (romNibble),
    .oprOut     (oprOut),
    .opaOut     (opaOut),
    .word2Out   (word2Out),
    .twoWord    (twoWord),
    .inWord2    (inWord2),
`ifdef IFL_ICOUNT_EN
    .instrCount (instrCount),
`endif
    .instrValid (instrValid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit modelTwoWord(input logic [3:0] opr, input logic [3:0] opa);
    case (opr)
      4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
      4'h2:                   return (opa % 2) == 0;
      default:                return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    mOpr = 0; mOpa = 0; mWord2 = 0; mTwo = 0; mIn2 = 0; mCount = 0;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_opr"},   16'(oprOut),     16'h0);
    chk({tag, "_opa"},   16'(opaOut),     16'h0);
    chk({tag, "_word2"}, 16'(word2Out),   16'h0);
    chk({tag, "_two"},   16'(twoWord),    16'h0);
    chk({tag, "_in2"},   16'(inWord2),    16'h0);
    chk({tag, "_valid"}, 16'(instrValid), 16'h0);
`ifdef IFL_ICOUNT_EN
    chk({tag, "_count"}, instrCount,      16'h0);
`endif
  endtask

  // One full instruction cycle carrying byte b; skip replaces M1/M2 phases.
  task automatic runInstr(input logic [7:0] b, input bit skip);
    bit expValid;
    bit wasIn2;
    wasIn2 = mIn2;
    if (!mIn2) begin
      if (!skip) begin
        mOpr = b[7:4]; mOpa = b[3:0]; mWord2 = 8'h00; mTwo = 1'b0;
      end
      if (modelTwoWord(mOpr, mOpa)) begin
        mTwo = 1'b1; mIn2 = 1'b1; expValid = 1'b0;
      end else begin
        expValid = 1'b1;
      end
    end else begin
      if (!skip) mWord2 = b;
      mIn2 = 1'b0;
      expValid = 1'b1;
    end
    if (expValid) mCount = mCount + 16'd1;

    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cycle     = (skip && (c == 3 || c == 4)) ? 3'd6 : 3'(c);
      romNibble = (c == 3) ? b[7:4] : (c == 4) ? b[3:0] : 4'($urandom);
      @(posedge clk);
      #1;
      if (c == 5) begin
        chk("x1_valid", 16'(instrValid), 16'(expValid));
        chk("x1_opr",   16'(oprOut),     16'(mOpr));
        chk("x1_opa",   16'(opaOut),     16'(mOpa));
        chk("x1_word2", 16'(word2Out),   16'(mWord2));
        chk("x1_two",   16'(twoWord),    16'(mTwo));
        chk("x1_in2",   16'(inWord2),    16'(mIn2));
      end else begin
        chk("idle_valid", 16'(instrValid), 16'h0);
      end
`ifdef IFL_ICOUNT_EN
      if (c == 6) chk("count", instrCount, mCount);
`endif
    end
    $display("instr byte=0x%02h skip=%0d word%0d valid=%0d opr=%h opa=%h word2=%02h two=%0d in2=%0d",
             b, skip, wasIn2 ? 2 : 1, instrValid, oprOut, opaOut, word2Out, twoWord, inWord2);
  endtask

  initial begin
    rstN = 1'b0; cycle = 3'd0; romNibble = 4'h0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rstN = 1'b1;

    // LDM 5
    runInstr(8'hD5, 1'b0);
    // JUN 0x43 0x12
    runInstr(8'h43, 1'b0);
    runInstr(8'h12, 1'b0);
    // FIM / SRC split
    runInstr(8'h20, 1'b0);
    runInstr(8'hAB, 1'b0);
    runInstr(8'h21, 1'b0);
    // Back-to-back NOPs
    runInstr(8'h00, 1'b0);
    runInstr(8'h00, 1'b0);
    runInstr(8'h00, 1'b0);
    // Skipped M1/M2 after a one-word instruction: stale fields reclassified
    runInstr(8'hD7, 1'b0);
    runInstr(8'h40, 1'b1);

    // JMS first word, then reset during cycle 2 of the second word
    runInstr(8'h57, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cycle = 3'(c);
      romNibble = 4'($urandom);
    end
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAllZero("midreset");
    @(negedge clk);
    rstN = 1'b1;
    $display("reset asserted in second word of JMS, outputs cleared");
    runInstr(8'hD1, 1'b0);

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      runInstr(8'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
